// File: rtl/cnn_pkg.sv
// Shared constants, load-FSM state type and lane/bank helper for the IFM server.
package cnn_pkg;

  localparam int IFM_DEPTH = 32768;
  localparam int IFM_ROW_W = 64;
  localparam int IFM_AW    = 15;
  localparam int LANES     = 4;
  localparam int ROWS      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  // Bank that holds lane k of a fetch whose first byte sits in bank 'off'.
  function automatic logic [1:0] lane_bank(input logic [1:0] off, input logic [1:0] k);
    return off + k;
  endfunction

endpackage

// File: rtl/cnn_ifm_server_if.sv
// Host load stream plus conv-core window read port of the IFM server.
interface cnn_ifm_server_if;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        loaded;
  logic [31:0] I_ram_addr;
  logic [63:0] I_ram_dout;
  logic        oob_err;

  modport master (
    output ld_start, ld_valid, ld_data, I_ram_addr,
    input  ld_ready, loaded, I_ram_dout, oob_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, I_ram_addr,
    output ld_ready, loaded, I_ram_dout, oob_err
  );
endinterface

// File: rtl/cnn_byte_bank.sv
// One byte-wide bank: a shared write port feeding one RAM copy per synchronous read port.
module cnn_byte_bank #(
  parameter int WORDS    = 8192,
  parameter int BW       = 13,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [BW-1:0]                waddr,
  input  logic [7:0]                   wdata,
  input  logic [RD_PORTS-1:0][BW-1:0]  raddr,
  output logic [RD_PORTS-1:0][7:0]     rdata
);

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_copy
      logic [7:0] mem [WORDS];
      logic [7:0] rdata_reg;

      // Read and write share the edge, so a colliding read returns the old byte.
      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr[gi]];
      end

      assign rdata[gi] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/cnn_ifm_server.sv
// IFM storage for the conv core: byte-stream loader and a 4x2 byte window read each cycle.
module cnn_ifm_server
  import cnn_pkg::*;
#(
  parameter int DEPTH = IFM_DEPTH,
  parameter int ROW_W = IFM_ROW_W,
  parameter int AW    = IFM_AW
) (
  input  logic              clk,
  input  logic              rst,
  cnn_ifm_server_if.slave   bus
);

  localparam int BW    = AW - 2;
  localparam int WORDS = DEPTH / 4;

  ld_state_e               state_reg, state_next;
  logic [AW-1:0]           ld_cnt_reg, ld_cnt_next;
  logic                    wr_en;

  logic [32:0]             lane_addr [ROWS][LANES];
  logic [ROWS*LANES-1:0]   lane_oob;
  logic [ROWS-1:0][BW-1:0] bank_raddr [LANES];
  logic [ROWS-1:0][7:0]    bank_rdata [LANES];
  logic [ROWS*LANES-1:0]   zero_reg;
  logic [ROWS-1:0][1:0]    off_reg;
  logic                    oob_err_reg;
  logic [63:0]             dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ld_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ld_cnt_reg <= ld_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ld_cnt_next = ld_cnt_reg;
    wr_en       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.ld_start) begin
          state_next  = LOAD;
          ld_cnt_next = '0;
        end
      end
      LOAD: begin
        // A restart wins over the byte offered in the same cycle.
        if (bus.ld_start) begin
          ld_cnt_next = '0;
        end else if (bus.ld_valid) begin
          wr_en       = 1'b1;
          ld_cnt_next = ld_cnt_reg + 1'b1;
          if (ld_cnt_reg == AW'(DEPTH - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.ld_start) begin
          state_next  = LOAD;
          ld_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ld_ready = (state_reg == LOAD);
  assign bus.loaded   = (state_reg == DONE);

  // 33-bit lane addresses so a carry out of the 32-bit address still counts as out of range.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < LANES; k++) begin
        lane_addr[r][k]          = {1'b0, bus.I_ram_addr} + 33'(r * ROW_W + k);
        lane_oob[r * LANES + k]  = (lane_addr[r][k] >= 33'(DEPTH));
      end
    end
  end

  // Bank j serves the lane k with (row offset + k) mod 4 == j.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      for (int r = 0; r < ROWS; r++) begin
        bank_raddr[j][r] = lane_addr[r][2'(j) - lane_addr[r][0][1:0]][AW-1:2];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
      cnn_byte_bank #(
        .WORDS    (WORDS),
        .BW       (BW),
        .RD_PORTS (ROWS)
      ) u_bank (
        .clk   (clk),
        .we    (wr_en && (ld_cnt_reg[1:0] == 2'(gi))),
        .waddr (ld_cnt_reg[AW-1:2]),
        .wdata (bus.ld_data),
        .raddr (bank_raddr[gi]),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Lane masks come up all-ones so the window output reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_reg    <= '1;
      off_reg     <= '0;
      oob_err_reg <= 1'b0;
    end else begin
      zero_reg    <= lane_oob;
      for (int r = 0; r < ROWS; r++) begin
        off_reg[r] <= lane_addr[r][0][1:0];
      end
      oob_err_reg <= oob_err_reg | (|lane_oob);
    end
  end

  always_comb begin
    dout = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < LANES; k++) begin
        dout[(r * LANES + k) * 8 +: 8] = zero_reg[r * LANES + k] ? 8'h00
                                       : bank_rdata[lane_bank(off_reg[r], 2'(k))][r];
      end
    end
  end

  assign bus.I_ram_dout = dout;
  assign bus.oob_err    = oob_err_reg;

endmodule

// File: tb/tb_cnn_ifm_server.sv
// Directed bench for cnn_ifm_server on a reduced 4 KiB image to keep load times short.
module tb_cnn_ifm_server;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int ROW_W = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  cnn_ifm_server_if bus ();

  cnn_ifm_server #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a);
    bus.I_ram_addr = a;
    step();
    $display("read   addr=%08h dout=%016h oob_err=%0b", a, bus.I_ram_dout, bus.oob_err);
  endtask

  // Full image load; n_acc counts accepted bytes, last_acc tells whether loaded rose right after an accept.
  task automatic load_image(input bit inv, input bit gaps, output int n_acc, output bit last_acc);
    int cyc;
    bit acc;
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b0;
    step();
    bus.ld_start = 1'b0;
    n_acc    = 0;
    last_acc = 1'b0;
    cyc      = 0;
    while (!bus.loaded && cyc < 4 * DEPTH + 100) begin
      bus.ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ld_data  = inv ? ~8'(n_acc) : 8'(n_acc);
      acc = bus.ld_valid && bus.ld_ready;
      step();
      if (acc) n_acc++;
      last_acc = acc;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    $display("load   inv=%0b gaps=%0b accepted=%0d cycles=%0d loaded=%0b", inv, gaps, n_acc, cyc, bus.loaded);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = 8'h00;
    bus.I_ram_addr = 32'h0;
    #2 rst = 1'b0;
    step();
    step();
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready); else passed++;
    checks++; if (bus.loaded !== 1'b0) $display("FAIL reset_loaded got=%b exp=0", bus.loaded); else passed++;
    checks++; if (bus.I_ram_dout !== 64'h0) $display("FAIL reset_dout got=%h exp=0", bus.I_ram_dout); else passed++;
    checks++; if (bus.oob_err !== 1'b0) $display("FAIL reset_oob_err got=%b exp=0", bus.oob_err); else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_aligned();
    int n; bit l;
    load_image(1'b0, 1'b0, n, l);
    checks++; if (n !== DEPTH) $display("FAIL aligned_count got=%0d exp=%0d", n, DEPTH); else passed++;
    checks++; if (bus.loaded !== 1'b1) $display("FAIL aligned_loaded got=%b exp=1", bus.loaded); else passed++;
    do_read(32'd0);
    checks++; if (bus.I_ram_dout !== 64'h43424140_03020100) $display("FAIL aligned_dout got=%h exp=%h", bus.I_ram_dout, 64'h43424140_03020100); else passed++;
    checks++; if (bus.oob_err !== 1'b0) $display("FAIL aligned_oob got=%b exp=0", bus.oob_err); else passed++;
  endtask

  task automatic test_unaligned();
    do_read(32'd5);
    checks++; if (bus.I_ram_dout !== 64'h48474645_08070605) $display("FAIL unaligned5_dout got=%h exp=%h", bus.I_ram_dout, 64'h48474645_08070605); else passed++;
    do_read(32'd62);
    checks++; if (bus.I_ram_dout !== 64'h81807F7E_41403F3E) $display("FAIL unaligned62_dout got=%h exp=%h", bus.I_ram_dout, 64'h81807F7E_41403F3E); else passed++;
    checks++; if (bus.oob_err !== 1'b0) $display("FAIL unaligned_oob got=%b exp=0", bus.oob_err); else passed++;
  endtask

  task automatic test_oob();
    do_read(32'(DEPTH - 2));
    checks++; if (bus.I_ram_dout !== 64'h00000000_0000FFFE) $display("FAIL oob_edge_dout got=%h exp=%h", bus.I_ram_dout, 64'h00000000_0000FFFE); else passed++;
    checks++; if (bus.oob_err !== 1'b1) $display("FAIL oob_edge_flag got=%b exp=1", bus.oob_err); else passed++;
    do_read(32'h8000_0004);
    checks++; if (bus.I_ram_dout !== 64'h0) $display("FAIL oob_high_dout got=%h exp=0", bus.I_ram_dout); else passed++;
    do_read(32'd0);
    checks++; if (bus.I_ram_dout !== 64'h43424140_03020100) $display("FAIL oob_legal_dout got=%h exp=%h", bus.I_ram_dout, 64'h43424140_03020100); else passed++;
    checks++; if (bus.oob_err !== 1'b1) $display("FAIL oob_sticky got=%b exp=1", bus.oob_err); else passed++;
  endtask

  task automatic test_gaps();
    int n; bit l;
    load_image(1'b0, 1'b1, n, l);
    checks++; if (n !== DEPTH) $display("FAIL gaps_count got=%0d exp=%0d", n, DEPTH); else passed++;
    checks++; if (bus.loaded !== 1'b1 || l !== 1'b1) $display("FAIL gaps_loaded_timing loaded=%b last_accept=%b exp=1/1", bus.loaded, l); else passed++;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL gaps_ready_after got=%b exp=0", bus.ld_ready); else passed++;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hAA;
    for (int i = 0; i < 8; i++) step();
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_ready !== 1'b0 || bus.loaded !== 1'b1) $display("FAIL gaps_extra_state ready=%b loaded=%b exp=0/1", bus.ld_ready, bus.loaded); else passed++;
    do_read(32'd0);
    checks++; if (bus.I_ram_dout !== 64'h43424140_03020100) $display("FAIL gaps_dout0 got=%h exp=%h", bus.I_ram_dout, 64'h43424140_03020100); else passed++;
    do_read(32'(DEPTH - 68));
    checks++; if (bus.I_ram_dout !== 64'hFFFEFDFC_BFBEBDBC) $display("FAIL gaps_dout_tail got=%h exp=%h", bus.I_ram_dout, 64'hFFFEFDFC_BFBEBDBC); else passed++;
  endtask

  task automatic test_reset_midload();
    int n, cyc; bit l;
    bus.I_ram_addr = 32'd0;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    n = 0; cyc = 0;
    while (n < 100 && cyc < 1000) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(n);
      if (bus.ld_ready) n++;
      step();
      cyc++;
    end
    checks++; if (bus.ld_ready !== 1'b1) $display("FAIL midrst_pre_ready got=%b exp=1", bus.ld_ready); else passed++;
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", bus.ld_ready); else passed++;
    checks++; if (bus.loaded !== 1'b0) $display("FAIL midrst_loaded got=%b exp=0", bus.loaded); else passed++;
    checks++; if (bus.I_ram_dout !== 64'h0) $display("FAIL midrst_dout got=%h exp=0", bus.I_ram_dout); else passed++;
    checks++; if (bus.oob_err !== 1'b0) $display("FAIL midrst_oob got=%b exp=0", bus.oob_err); else passed++;
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.ld_ready !== 1'b0) $display("FAIL midrst_idle_ready got=%b exp=0", bus.ld_ready); else passed++;
    load_image(1'b0, 1'b0, n, l);
    checks++; if (n !== DEPTH) $display("FAIL midrst_reload_count got=%0d exp=%0d", n, DEPTH); else passed++;
    do_read(32'd0);
    checks++; if (bus.I_ram_dout !== 64'h43424140_03020100) $display("FAIL midrst_reload_dout got=%h exp=%h", bus.I_ram_dout, 64'h43424140_03020100); else passed++;
  endtask

  task automatic test_restart();
    int n, cyc;
    bit acc, restarted, probed;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    n = 0; cyc = 0; restarted = 1'b0; probed = 1'b0;
    while (!bus.loaded && cyc < 4 * DEPTH + 100) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = ~8'(n);
      if (!restarted && n == 200) begin
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        $display("restart at byte %0d", n);
        restarted = 1'b1;
        n = 0;
      end else begin
        if (restarted && !probed && n == 300) bus.I_ram_addr = 32'd300;
        acc = bus.ld_ready;
        step();
        if (restarted && !probed && n == 300) begin
          probed = 1'b1;
          checks++; if (bus.I_ram_dout !== 64'h6F6E6D6C_2F2E2D2C) $display("FAIL rbw_dout got=%h exp=%h", bus.I_ram_dout, 64'h6F6E6D6C_2F2E2D2C); else passed++;
        end
        if (acc) n++;
      end
      cyc++;
    end
    bus.ld_valid = 1'b0;
    $display("load   inv=1 restart accepted=%0d loaded=%0b", n, bus.loaded);
    checks++; if (probed !== 1'b1) $display("FAIL rbw_probe_reached got=%b exp=1", probed); else passed++;
    checks++; if (n !== DEPTH || bus.loaded !== 1'b1) $display("FAIL restart_count got=%0d loaded=%b exp=%0d/1", n, bus.loaded, DEPTH); else passed++;
    do_read(32'd0);
    checks++; if (bus.I_ram_dout !== 64'hBCBDBEBF_FCFDFEFF) $display("FAIL restart_dout0 got=%h exp=%h", bus.I_ram_dout, 64'hBCBDBEBF_FCFDFEFF); else passed++;
    do_read(32'(DEPTH - 68));
    checks++; if (bus.I_ram_dout !== 64'h00010203_40414243) $display("FAIL restart_dout_tail got=%h exp=%h", bus.I_ram_dout, 64'h00010203_40414243); else passed++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_oob();
    test_gaps();
    test_reset_midload();
    test_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
